// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial line and the byte hand-off towards the byte register.
//   rx        : asynchronous serial input, idle high
//   dout      : last valid received byte
//   wr_req    : byte-ready strobe (fixed-width high pulse)
//   frame_err : one-cycle pulse on a low stop bit
// master : the receiver (consumes rx, drives the byte side)
// slave  : line driver / byte consumer
// -----------------------------------------------------------------------------
interface uart_rx_if;
    logic       rx;
    logic [7:0] dout;
    logic       wr_req;
    logic       frame_err;

    modport master (
        input  rx,
        output dout,
        output wr_req,
        output frame_err
    );

    modport slave (
        output rx,
        input  dout,
        input  wr_req,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling 8N1 receiver front end. Deframes characters from the serial
// line and hands each valid byte to the downstream byte register with a
// fixed-width wr_req pulse; dout is held until the next valid frame.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : uart_rx_if.master (rx in; dout, wr_req, frame_err out)
// Parameters:
//   CLKS_PER_BIT : clock cycles per bit period (>= 8)
//   REQ_CYCLES   : wr_req pulse width (>= 3, < CLKS_PER_BIT/2)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int REQ_CYCLES   = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int REQ_W = $clog2(REQ_CYCLES + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [REQ_W-1:0] REQ_LOAD  = REQ_W'(REQ_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic [7:0]       dout_q;
    logic [7:0]       dout_next;
    logic [REQ_W-1:0] req_cnt;
    logic [REQ_W-1:0] req_cnt_next;
    logic             ferr_q;
    logic             ferr_next;

    // Two-flop synchroniser; both stages reset to the idle (high) line level
    // so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath decisions. The request counter runs on its own
    // regardless of the FSM; a valid stop bit reloads it. Overlap with a
    // running pulse cannot happen because REQ_CYCLES < half a bit period.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        dout_next    = dout_q;
        ferr_next    = 1'b0;
        req_cnt_next = (req_cnt != '0) ? (req_cnt - REQ_W'(1)) : req_cnt;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end

            // Re-check the start bit at its middle to reject short glitches.
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            // Counting from the start-bit middle keeps every sample mid-bit.
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        dout_next    = shift;
                        req_cnt_next = REQ_LOAD;
                        state_next   = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            // A line stuck low must return high before a new start is armed.
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            dout_q  <= 8'h00;
            req_cnt <= '0;
            ferr_q  <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            dout_q  <= dout_next;
            req_cnt <= req_cnt_next;
            ferr_q  <= ferr_next;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.wr_req    = (req_cnt != '0);
    assign bus.frame_err = ferr_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver front end for the UART datapath: oversamples the asynchronous `rx` line, deframes 8N1 characters, and hands each valid byte to the downstream register stage. It sits directly upstream of the byte register. The consumer synchronises `wr_req` through two flops and captures `dout` on the falling edge of `wr_req`. `uart_rx` therefore presents a stable byte, pulses `wr_req` high for a fixed width, and holds `dout` until the next valid frame.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per bit period (100 MHz / 115200). Must be ≥ 8.
- `REQ_CYCLES`, 4: width of the `wr_req` high pulse. Must be ≥ 3 and < `CLKS_PER_BIT/2`.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `rx`, in, 1: asynchronous serial input; idle high.
- `dout`, out, 8: last valid received byte.
- `wr_req`, out, 1: byte-ready strobe; high for exactly `REQ_CYCLES` cycles per valid frame.
- `frame_err`, out, 1: one-cycle pulse when the stop bit samples low.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser (`rx_s`), both flops reset to 1. All decisions use `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. Bit counter is 3 bits; cycle counter is wide enough for `CLKS_PER_BIT-1`.
- **IDLE:**
  - `rx_s`=0 → START, cycle counter cleared.
- **START:**
  - At count `CLKS_PER_BIT/2 - 1` (floor), sample `rx_s`.
  - If 0 → DATA, counter cleared, bit index 0.
  - If 1 → false start, back to IDLE.
- **DATA:**
  - Sample `rx_s` each time the counter reaches `CLKS_PER_BIT-1`, then clear the counter.
  - Shift LSB first into a shift register.
  - After bit 7 → STOP.
- **STOP:** sample at count `CLKS_PER_BIT-1`.
  - If 1:
    - Load `dout` from the shift register.
    - Load the request counter with `REQ_CYCLES`.
    - Go to IDLE.
  - If 0:
    - Pulse `frame_err` for one cycle.
    - `dout` unchanged; no `wr_req`.
    - Go to BREAK.
- **BREAK:** wait until `rx_s`=1, then go to IDLE. A line held low never produces spurious frames.
- **Request counter:** independent of the FSM.
  - `wr_req` = (counter ≠ 0).
  - Counter decrements each cycle while nonzero.
- **`dout` stability:** `dout` changes only on a valid stop bit. It is stable from `wr_req` rise until the next valid frame, which is at least ~9.5 bit periods later. This satisfies the consumer's falling-edge capture after its 2-flop synchroniser.
- **Frame completion during an active `wr_req`:** cannot occur given the `REQ_CYCLES` constraint. No queueing is provided.
- **Reset** (any state, including mid-frame):
  - FSM → IDLE; counters cleared.
  - `dout`=8'h00, `wr_req`=0, `frame_err`=0.
  - Synchroniser flops = 1.
  - A frame in flight at reset is discarded.

## Timing
- Edge-to-detect latency: 2 cycles (synchroniser) plus 1 cycle (IDLE→START).
- Sample points: mid-bit, i.e. ≈ `CLKS_PER_BIT/2` after the detected start edge, then every `CLKS_PER_BIT`.
- `dout` update and `wr_req` rise occur on the same clock edge, at the stop-bit mid-sample + 1 cycle.
- `wr_req` stays high exactly `REQ_CYCLES` cycles, then low.
- `frame_err` is high exactly 1 cycle, on the edge following the low stop-bit sample.
- Back-to-back frames: after a valid stop sample the FSM is in IDLE ~½ bit before the next start edge. A start bit immediately following the stop bit is accepted.
- Minimum tolerated baud mismatch: ±4% (mid-bit sampling over 10 bits).

## Test plan
- **Valid frame:** `CLKS_PER_BIT`=16, `REQ_CYCLES`=4, send 0xA5 8N1 → `dout`=0xA5; `wr_req` high exactly 4 cycles, rising the cycle after the stop sample; `frame_err` stays 0.
- **Glitch rejection:** `rx` low for 5 cycles, then high → FSM returns to IDLE from START; no `wr_req`, no `frame_err`, `dout` unchanged.
- **Framing error and break:**
  - After 0xA5, send 0x3C with stop bit = 0 → one-cycle `frame_err`, `dout` stays 0xA5, no `wr_req`.
  - Hold `rx` low 40 cycles, release, then send 0x01 → `dout`=0x01 with one `wr_req` pulse.
- **Back-to-back frames:** 0x00 then 0xFF with no idle gap → two `wr_req` pulses, each 4 cycles. `dout`=0x00 then 0xFF, and each value holds constant until the next `wr_req` rise.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during DATA bit 3 → next cycle `dout`=0x00, `wr_req`=0, `frame_err`=0. A following frame 0x5A is received correctly.
- **Consumer-side check:** model a 2-flop synchroniser plus falling-edge capture on `wr_req`; send 0x5A → captured byte = 0x5A; `dout` unchanged for ≥ 3 cycles after `wr_req` falls.
